// File: rtl/calib_led_pattern_gen.sv
// calib_led_pattern_gen: serves the binary LED-ID pattern one bit plane at a time.
// Optional macro COMPLEMENT_PHASE_EN shows each plane twice, second time inverted.
module calib_led_pattern_gen #(
    parameter int NUM_LEDS = 50,
    parameter int LED_ADDRESS_WIDTH = 10,
    parameter int ID_OFFSET = 1,
    parameter int COLOR_WIDTH = 24,
    parameter logic [COLOR_WIDTH-1:0] ON_COLOR = 24'hFFFFFF,
    parameter logic [COLOR_WIDTH-1:0] OFF_COLOR = 24'h000000,
    localparam int BIT_W = (LED_ADDRESS_WIDTH > 1) ? $clog2(LED_ADDRESS_WIDTH) : 1,
    localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                   clk_pixel,
    input  logic                   rst_n,
    input  logic                   start_in,
    input  logic                   advance_in,
    input  logic                   next_led_request,
    input  logic                   strand_latched_in,
    output logic [COLOR_WIDTH-1:0] led_color_out,
    output logic                   led_color_valid,
    output logic                   displayed_frame_valid,
    output logic [BIT_W-1:0]       bit_index_out,
    output logic                   phase_out,
    output logic                   busy_out,
    output logic                   sweep_done
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        WAIT_LATCH,
        SHOWN
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0]             led_index;
    logic [BIT_W-1:0]             bit_index;
    logic [LED_ADDRESS_WIDTH-1:0] led_id;
    logic start_prev;
    logic advance_prev;
    logic start_edge;
    logic advance_edge;
    logic streaming;
    logic last_led;
    logic last_bit;
    logic phase;
    logic phase_done;
    logic plane_step;
    logic plane_last;
    logic lit;

    assign start_edge   = start_in & ~start_prev;
    assign advance_edge = advance_in & ~advance_prev;
    assign streaming    = (state == STREAM);
    assign last_led     = (led_index == IDX_W'(NUM_LEDS - 1));
    assign last_bit     = (bit_index == BIT_W'(LED_ADDRESS_WIDTH - 1));

    // ID wraps modulo 2^LED_ADDRESS_WIDTH through the sized add
    assign led_id = LED_ADDRESS_WIDTH'(led_index) + LED_ADDRESS_WIDTH'(ID_OFFSET);

`ifdef COMPLEMENT_PHASE_EN
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 1'b0;
        end else if (state == SHOWN && advance_edge) begin
            phase <= ~phase;
        end
    end

    assign phase_done = phase;
    assign lit        = led_id[bit_index] ^ phase;
`else
    assign phase      = 1'b0;
    assign phase_done = 1'b1;
    assign lit        = led_id[bit_index];
`endif

    // A plane is finished only when its last phase is advanced past
    assign plane_step = (state == SHOWN) & advance_edge & phase_done;
    assign plane_last = phase_done & last_bit;

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start_edge) state_next = STREAM;
            end
            STREAM: begin
                if (next_led_request && last_led) state_next = WAIT_LATCH;
            end
            WAIT_LATCH: begin
                if (strand_latched_in) state_next = SHOWN;
            end
            SHOWN: begin
                if (advance_edge) begin
                    state_next = plane_last ? IDLE : STREAM;
                end else if (start_edge) begin
                    state_next = STREAM;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_out      = (state != IDLE);
        bit_index_out = bit_index;
        phase_out     = phase;
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            led_index             <= '0;
            bit_index             <= '0;
            led_color_out         <= '0;
            led_color_valid       <= 1'b0;
            displayed_frame_valid <= 1'b0;
            sweep_done            <= 1'b0;
            start_prev            <= 1'b0;
            advance_prev          <= 1'b0;
        end else begin
            start_prev      <= start_in;
            advance_prev    <= advance_in;
            led_color_valid <= next_led_request;
            sweep_done      <= 1'b0;

            if (next_led_request) begin
                led_color_out <= (streaming && lit) ? ON_COLOR : OFF_COLOR;
            end

            if (streaming && next_led_request) begin
                led_index <= last_led ? '0 : led_index + IDX_W'(1);
            end else if (!streaming && state_next == STREAM) begin
                led_index <= '0;
            end

            if (state == WAIT_LATCH && strand_latched_in) begin
                displayed_frame_valid <= 1'b1;
            end else if (state == SHOWN && (advance_edge || start_edge)) begin
                displayed_frame_valid <= 1'b0;
            end

            if (plane_step) begin
                bit_index  <= plane_last ? '0 : bit_index + BIT_W'(1);
                sweep_done <= plane_last;
            end
        end
    end

endmodule

// File: tb/tb_calib_led_pattern_gen.sv
// tb_calib_led_pattern_gen: vector table, directed corner sequences and
// randomized traffic checked against a plane-level reference model.
`timescale 1ns/1ps
module tb_calib_led_pattern_gen;

    localparam int N    = 4;
    localparam int W    = 3;
    localparam int OFFS = 1;
    localparam int CW   = 24;
    localparam logic [CW-1:0] ON  = 24'hFFFFFF;
    localparam logic [CW-1:0] OFF = 24'h000000;
`ifdef COMPLEMENT_PHASE_EN
    localparam bit COMP = 1'b1;
`else
    localparam bit COMP = 1'b0;
`endif

    localparam int M_IDLE   = 0;
    localparam int M_STREAM = 1;
    localparam int M_WAIT   = 2;
    localparam int M_SHOWN  = 3;

    logic clk_pixel = 1'b0;
    logic rst_n = 1'b0;
    logic start_in = 1'b0;
    logic advance_in = 1'b0;
    logic next_led_request = 1'b0;
    logic strand_latched_in = 1'b0;
    logic [CW-1:0] led_color_out;
    logic led_color_valid;
    logic displayed_frame_valid;
    logic [1:0] bit_index_out;
    logic phase_out;
    logic busy_out;
    logic sweep_done;

    calib_led_pattern_gen #(
        .NUM_LEDS(N),
        .LED_ADDRESS_WIDTH(W),
        .ID_OFFSET(OFFS),
        .COLOR_WIDTH(CW),
        .ON_COLOR(ON),
        .OFF_COLOR(OFF)
    ) dut (
        .clk_pixel(clk_pixel),
        .rst_n(rst_n),
        .start_in(start_in),
        .advance_in(advance_in),
        .next_led_request(next_led_request),
        .strand_latched_in(strand_latched_in),
        .led_color_out(led_color_out),
        .led_color_valid(led_color_valid),
        .displayed_frame_valid(displayed_frame_valid),
        .bit_index_out(bit_index_out),
        .phase_out(phase_out),
        .busy_out(busy_out),
        .sweep_done(sweep_done)
    );

    always #5 clk_pixel = ~clk_pixel;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;

    int m_mode;
    int m_idx;
    int m_bit;
    bit m_phase;
    bit m_ps;
    bit m_pa;
    logic [CW-1:0] e_col;
    bit e_val;
    bit e_dfv;
    bit e_done;

    typedef struct {
        bit s; bit a; bit r; bit l;
        bit val; logic [CW-1:0] col;
        bit dfv; int bitx; bit ph; bit busy; bit done;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit id_bit(input int idx, input int b);
        int id;
        id = (idx + OFFS) % (1 << W);
        return ((id / (1 << b)) % 2) == 1;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_idx = 0; m_bit = 0; m_phase = 0;
        m_ps = 0; m_pa = 0;
        e_col = '0; e_val = 0; e_dfv = 0; e_done = 0;
    endtask

    task automatic model_step(input bit s, input bit a, input bit r, input bit l);
        bit se;
        bit ae;
        int old;
        se = s && !m_ps;
        ae = a && !m_pa;
        m_ps = s;
        m_pa = a;
        old = m_mode;
        e_done = 0;
        e_val = r;
        if (r) begin
            e_col = OFF;
            if (old == M_STREAM) begin
                e_col = (id_bit(m_idx, m_bit) ^ m_phase) ? ON : OFF;
                m_idx++;
                if (m_idx == N) begin
                    m_idx = 0;
                    m_mode = M_WAIT;
                end
            end
        end
        case (old)
            M_IDLE: if (se) begin m_mode = M_STREAM; m_idx = 0; end
            M_WAIT: if (l) begin m_mode = M_SHOWN; e_dfv = 1; end
            M_SHOWN: begin
                if (ae) begin
                    e_dfv = 0;
                    if (COMP && !m_phase) begin
                        m_phase = 1;
                        m_mode = M_STREAM;
                    end else begin
                        m_phase = 0;
                        if (m_bit < W - 1) begin
                            m_bit++;
                            m_mode = M_STREAM;
                        end else begin
                            m_bit = 0;
                            e_done = 1;
                            m_mode = M_IDLE;
                        end
                    end
                end else if (se) begin
                    e_dfv = 0;
                    m_mode = M_STREAM;
                    m_idx = 0;
                end
            end
            default: ;
        endcase
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".valid"}, 32'(led_color_valid), 32'(e_val));
        chk({tag, ".color"}, 32'(led_color_out), 32'(e_col));
        chk({tag, ".dfv"}, 32'(displayed_frame_valid), 32'(e_dfv));
        chk({tag, ".bit"}, 32'(bit_index_out), 32'(m_bit));
        chk({tag, ".phase"}, 32'(phase_out), 32'(m_phase));
        chk({tag, ".busy"}, 32'(busy_out), 32'(m_mode != M_IDLE));
        chk({tag, ".done"}, 32'(sweep_done), 32'(e_done));
    endtask

    // Called at a negedge; returns at the following negedge
    task automatic step(input string tag, input bit s, input bit a, input bit r, input bit l);
        start_in = s; advance_in = a; next_led_request = r; strand_latched_in = l;
        model_step(s, a, r, l);
        @(posedge clk_pixel);
        #1;
        cmp_model(tag);
        if (sweep_done) done_seen++;
        @(negedge clk_pixel);
    endtask

    task automatic async_reset(input bit hold_start);
        #2;
        start_in = hold_start; advance_in = 0; next_led_request = 0; strand_latched_in = 0;
        rst_n = 1'b0;
        model_reset();
        #1;
        cmp_model("async_reset");
        @(negedge clk_pixel);
        @(negedge clk_pixel);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input bit s, input bit a, input bit r, input bit l,
                                input bit val, input logic [CW-1:0] col, input bit dfv,
                                input int bitx, input bit ph, input bit busy);
        vec_t v;
        v.s = s; v.a = a; v.r = r; v.l = l;
        v.val = val; v.col = col; v.dfv = dfv;
        v.bitx = bitx; v.ph = ph; v.busy = busy; v.done = 0;
        return v;
    endfunction

    initial begin
        int p1_bit;
        int guard;
        p1_bit = COMP ? 0 : 1;
        tbl.push_back(mk(0,0,0,0, 0, OFF, 0, 0, 0, 0));
        tbl.push_back(mk(1,0,0,0, 0, OFF, 0, 0, 0, 1));
        tbl.push_back(mk(1,0,1,0, 1, ON,  0, 0, 0, 1));
        tbl.push_back(mk(0,0,1,0, 1, OFF, 0, 0, 0, 1));
        tbl.push_back(mk(0,0,1,0, 1, ON,  0, 0, 0, 1));
        tbl.push_back(mk(0,0,1,0, 1, OFF, 0, 0, 0, 1));
        tbl.push_back(mk(1,0,0,0, 0, OFF, 0, 0, 0, 1));
        tbl.push_back(mk(0,0,0,1, 0, OFF, 1, 0, 0, 1));
        tbl.push_back(mk(0,0,0,0, 0, OFF, 1, 0, 0, 1));
        tbl.push_back(mk(0,1,0,0, 0, OFF, 0, p1_bit, COMP, 1));
        tbl.push_back(mk(0,0,1,0, 1, OFF, 0, p1_bit, COMP, 1));
        tbl.push_back(mk(0,0,1,0, 1, ON,  0, p1_bit, COMP, 1));
        tbl.push_back(mk(0,0,1,0, 1, COMP ? OFF : ON, 0, p1_bit, COMP, 1));
        tbl.push_back(mk(0,0,1,0, 1, COMP ? ON : OFF, 0, p1_bit, COMP, 1));

        model_reset();
        repeat (2) @(negedge clk_pixel);
        cmp_model("reset");
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            start_in = tbl[i].s; advance_in = tbl[i].a;
            next_led_request = tbl[i].r; strand_latched_in = tbl[i].l;
            model_step(tbl[i].s, tbl[i].a, tbl[i].r, tbl[i].l);
            @(posedge clk_pixel);
            #1;
            chk($sformatf("vec%0d.valid", i), 32'(led_color_valid), 32'(tbl[i].val));
            if (tbl[i].val) chk($sformatf("vec%0d.color", i), 32'(led_color_out), 32'(tbl[i].col));
            chk($sformatf("vec%0d.dfv", i), 32'(displayed_frame_valid), 32'(tbl[i].dfv));
            chk($sformatf("vec%0d.bit", i), 32'(bit_index_out), 32'(tbl[i].bitx));
            chk($sformatf("vec%0d.phase", i), 32'(phase_out), 32'(tbl[i].ph));
            chk($sformatf("vec%0d.busy", i), 32'(busy_out), 32'(tbl[i].busy));
            chk($sformatf("vec%0d.done", i), 32'(sweep_done), 32'(tbl[i].done));
            @(negedge clk_pixel);
        end

        // Finish the sweep: stream, latch and advance until back in IDLE
        done_seen = 0;
        guard = 0;
        while (m_mode != M_IDLE && guard < 200) begin
            guard++;
            if (m_mode == M_STREAM) step("sweep", 0, 0, 1, 0);
            else if (m_mode == M_WAIT) step("sweep", 0, 0, 0, 1);
            else begin
                step("sweep", 0, 1, 0, 0);
                step("sweep", 0, 0, 0, 0);
            end
        end
        step("sweep_idle", 0, 0, 0, 0);
        chk("sweep_done_count", 32'(done_seen), 32'd1);
        chk("sweep_end_bit", 32'(bit_index_out), 32'd0);
        chk("sweep_end_busy", 32'(busy_out), 32'd0);
        chk("sweep_end_dfv", 32'(displayed_frame_valid), 32'd0);

        // Request in IDLE, then start serves LED 0 first
        step("idle_req", 0, 0, 1, 0);
        chk("idle_req_color", 32'(led_color_out), 32'(OFF));
        step("idle_start", 1, 0, 0, 0);
        step("first_led", 0, 0, 1, 0);
        chk("first_led_color", 32'(led_color_out), 32'(ON));
        step("second_led", 0, 0, 1, 0);

        // Reset mid-stream with start held through release
        async_reset(1'b1);
        step("post_rst_edge", 1, 0, 0, 0);
        chk("post_rst_busy", 32'(busy_out), 32'd1);
        step("post_rst_led0", 1, 0, 1, 0);
        chk("post_rst_led0_color", 32'(led_color_out), 32'(ON));

        // Start edge in SHOWN re-streams the same plane
        guard = 0;
        while (m_mode != M_SHOWN && guard < 20) begin
            guard++;
            if (m_mode == M_STREAM) step("restream", 0, 0, 1, 0);
            else step("restream", 0, 0, 0, 1);
        end
        step("restream_start", 1, 0, 0, 0);
        chk("restream_busy", 32'(busy_out), 32'd1);
        step("restream_led0", 0, 0, 1, 0);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                async_reset(1'($urandom_range(0, 1)));
            end
            step("rand",
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 4) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/calib_led_pattern_gen.md
Name: calib_led_pattern_gen

Overview:
Upstream stage of the calibration FSM. Drives the LED strand with the binary ID pattern for one bit plane at a time: for bit k, an LED is lit when bit k of its ID is set. Serves colours on demand to the strand driver. Once the strand has latched the full frame, it raises displayed_frame_valid, which the calibration FSM consumes. Advances through all LED_ADDRESS_WIDTH bit planes for one full calibration sweep.

Parameters:
NUM_LEDS, 50, LEDs on the strand; LED index range 0..NUM_LEDS-1.
LED_ADDRESS_WIDTH, 10, ID width; number of bit planes.
ID_OFFSET, 1, ID = led_index + ID_OFFSET, so no LED is all-dark; ID computed modulo 2^LED_ADDRESS_WIDTH.
COLOR_WIDTH, 24, width of the colour word.
ON_COLOR, 24'hFFFFFF, colour for a set bit.
OFF_COLOR, 24'h000000, colour for a clear bit.

Ports:
clk_pixel  in  1  clock
rst_n  in  1  asynchronous, active-low reset
start_in  in  1  level input; rising edge starts streaming the current bit plane
advance_in  in  1  level input; rising edge moves to the next bit plane
next_led_request  in  1  single-cycle request for the next colour, from the strand driver
strand_latched_in  in  1  pulse from the strand driver: latch/reset period complete
led_color_out  out  COLOR_WIDTH  colour answering a request
led_color_valid  out  1  one-cycle qualifier for led_color_out
displayed_frame_valid  out  1  the strand is showing the current bit plane
bit_index_out  out  $clog2(LED_ADDRESS_WIDTH)  current bit plane
phase_out  out  1  complement phase (see Optional Feature)
busy_out  out  1  high in any state except IDLE
sweep_done  out  1  one-cycle pulse after the last bit plane

Behaviour:
- Reset (async assert, synchronous release): state IDLE, led_index 0, bit_index 0, phase 0, all outputs 0, edge-detect history registers 0. An input already high at release counts as a rising edge on the first clock.
- Rising-edge detection: registered previous value; edge = in & ~prev.
- States: IDLE, STREAM, WAIT_LATCH, SHOWN.
- IDLE: on a start edge, go to STREAM with led_index=0.
- STREAM: a request in cycle N gives led_color_valid=1 in N+1, for exactly one cycle. led_color_out is ON_COLOR if bit bit_index of (led_index+ID_OFFSET) is set, else OFF_COLOR. led_index then increments. When the request for led_index NUM_LEDS-1 is served, go to WAIT_LATCH and clear led_index to 0.
- Requests outside STREAM: answered with OFF_COLOR and valid in N+1. led_index is unchanged.
- WAIT_LATCH: on strand_latched_in, go to SHOWN. displayed_frame_valid goes 1 in the cycle after the pulse.
- SHOWN: displayed_frame_valid is held 1. On an advance edge, displayed_frame_valid clears in the next cycle. Then:
  - if bit_index < LED_ADDRESS_WIDTH-1: bit_index++ and go to STREAM directly (no start needed).
  - else: bit_index wraps to 0, sweep_done pulses for 1 cycle, go to IDLE.
- A start edge in SHOWN re-streams the same bit plane: displayed_frame_valid clears and the state goes to STREAM.
- Start and advance edges in the same cycle in SHOWN: advance wins.
- Start edges in STREAM/WAIT_LATCH and advance edges outside SHOWN are ignored and not queued.
- strand_latched_in outside WAIT_LATCH is ignored.
- Reset mid-stream: everything returns to reset values immediately. Any partially served frame is abandoned.
- busy_out is combinational from state.

Optional Feature:
Macro COMPLEMENT_PHASE_EN.
- Defined: each bit plane is shown twice, phase 0 (true pattern) then phase 1 (ON/OFF swapped). In SHOWN, an advance edge in phase 0 sets phase=1 and re-enters STREAM with the same bit_index. An advance edge in phase 1 clears phase and applies the normal bit-advance/wrap rules. Reset clears phase. phase_out reflects phase.
- Undefined: phase_out is tied 0 and there is no complement logic.

Test Plan:
1. NUM_LEDS=4, LED_ADDRESS_WIDTH=3, ID_OFFSET=1: reset, start edge, 4 requests -> colours ON,OFF,ON,OFF (IDs 1..4, bit 0), each valid 1 cycle after its request; state WAIT_LATCH.
2. Same configuration: strand_latched_in -> displayed_frame_valid=1 next cycle and held. Advance edge -> bit_index_out=1; next 4 requests give OFF,ON,ON,OFF.
3. Advance through bit 2 -> sweep_done pulses once, bit_index_out=0, busy_out=0, displayed_frame_valid=0.
4. Request while IDLE -> OFF_COLOR with valid. A following start then serves led_index 0 first (counter untouched).
5. rst_n low after 2 of 4 requests, release, start -> led_index 0 served first. Also: a start held high through release is detected as an edge.
6. With COMPLEMENT_PHASE_EN: bit 0 phase 1 serves OFF,ON,OFF,ON with phase_out=1. The following advance gives bit_index_out=1, phase_out=0.
